// File: rtl/ram_stream_fetch_buffer_pkg.sv
// Shared types, default widths and the lane-enable helper for the strided RAM fetch buffer.
package ram_stream_fetch_buffer_pkg;

  localparam int unsigned RSFB_DW       = 128;
  localparam int unsigned RSFB_AW       = 8;
  localparam int unsigned RSFB_DEPTH    = 16;
  localparam int unsigned RSFB_LEN_W    = 8;
  localparam int unsigned RSFB_STRIDE_W = 5;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'b00,
    FSM_FETCH = 2'b01,
    FSM_DRAIN = 2'b10
  } fsm_state_e;

  // A lane is enabled unless it falls before start on the first beat or after stop on the last beat.
  function automatic logic lane_en(input int unsigned lane, input logic first, input logic last,
                                   input int unsigned start, input int unsigned stop);
    return (!first || (lane >= start)) && (!last || (lane <= stop));
  endfunction

endpackage

// File: rtl/ram_stream_fifo.sv
// In-order word buffer between RAM read returns and the MXU stream; flop array with wrap-bit pointers.
module ram_stream_fifo #(
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data_c,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr_q;
  logic [PW:0]   rd_ptr_q;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  assign empty_c   = (cnt == '0);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_ok     = rd_en && !empty_c;
  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign wr_ok     = wr_en && (!full || rd_ok);
  assign rd_data_c = mem[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt      <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_fetch_buffer.sv
// Strided RAM fetch engine: issues credit-limited reads for one command and streams masked beats to the MXU.
module ram_stream_fetch_buffer
  import ram_stream_fetch_buffer_pkg::*;
#(
  parameter int unsigned DW       = RSFB_DW,
  parameter int unsigned AW       = RSFB_AW,
  parameter int unsigned DEPTH    = RSFB_DEPTH,
  parameter int unsigned LEN_W    = RSFB_LEN_W,
  parameter int unsigned STRIDE_W = RSFB_STRIDE_W,
  localparam int unsigned SW      = DW / 8,
  localparam int unsigned BW      = $clog2(SW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [STRIDE_W-1:0] cmd_stride,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [BW-1:0]       cmd_start_byte,
  input  logic [BW-1:0]       cmd_end_byte,
  output logic                ram_rd_vld,
  input  logic                ram_rd_rdy,
  output logic [AW-1:0]       ram_rd_addr,
  input  logic                ram_rsp_vld,
  input  logic [DW-1:0]       ram_rsp_data,
  output logic                mxu_vld,
  input  logic                mxu_rdy,
  output logic [DW-1:0]       mxu_data,
  output logic [SW-1:0]       mxu_strb,
  output logic                mxu_last,
  output logic                busy,
  output logic                err_rsp
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  fsm_state_e          state_q, state_d;
  logic [AW-1:0]       addr_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [LEN_W-1:0]    len_q;
  logic [BW-1:0]       start_q;
  logic [BW-1:0]       end_q;
  logic [LEN_W-1:0]    issue_cnt_q;
  logic [LEN_W-1:0]    send_cnt_q;
  logic [CW-1:0]       outstanding_q;
  logic [CW-1:0]       fifo_cnt;
  logic                fifo_empty;
  logic [DW-1:0]       head_data;
  logic                credit_ok;
  logic                cmd_acc;
  logic                rd_fire;
  logic                rsp_ok;
  logic                beat_fire;
  logic                beat_first;
  logic                beat_last;
  logic [AW-1:0]       stride_ext;

  // In-flight reads plus held words never exceed the buffer, so every return has a slot.
  assign credit_ok  = (({1'b0, outstanding_q} + {1'b0, fifo_cnt}) < CREDIT_MAX);
  assign rsp_ok     = ram_rsp_vld && (outstanding_q != '0);
  assign stride_ext = AW'($signed(stride_q));
  assign busy       = (state_q != FSM_IDLE);
  assign ram_rd_addr = addr_q;

  assign mxu_vld    = !fifo_empty;
  assign beat_fire  = mxu_vld && mxu_rdy;
  assign beat_first = (send_cnt_q == '0);
  assign beat_last  = (send_cnt_q == len_q);
  assign mxu_last   = beat_last && mxu_vld;

  ram_stream_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rsp_ok),
    .wr_data   (ram_rsp_data),
    .rd_en     (beat_fire),
    .rd_data_c (head_data),
    .cnt       (fifo_cnt),
    .empty_c   (fifo_empty)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    cmd_rdy    = 1'b0;
    cmd_acc    = 1'b0;
    ram_rd_vld = 1'b0;
    rd_fire    = 1'b0;
    case (state_q)
      FSM_IDLE: begin
        cmd_rdy = 1'b1;
        cmd_acc = cmd_vld;
        if (cmd_vld) state_d = FSM_FETCH;
      end
      FSM_FETCH: begin
        ram_rd_vld = credit_ok;
        rd_fire    = credit_ok && ram_rd_rdy;
        if (rd_fire && (issue_cnt_q == len_q)) state_d = FSM_DRAIN;
      end
      FSM_DRAIN: begin
        if (beat_fire && beat_last) state_d = FSM_IDLE;
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  // Byte masking of the FIFO head; disabled lanes are forced to zero.
  always_comb begin
    mxu_strb = '0;
    mxu_data = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      mxu_strb[i] = mxu_vld && lane_en(i, beat_first, beat_last, 32'(start_q), 32'(end_q));
      mxu_data[i*8 +: 8] = mxu_strb[i] ? head_data[i*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FSM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
    end else if (cmd_acc) begin
      addr_q      <= cmd_addr;
      stride_q    <= cmd_stride;
      len_q       <= cmd_len;
      start_q     <= cmd_start_byte;
      end_q       <= cmd_end_byte;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
    end else begin
      if (rd_fire) begin
        addr_q      <= addr_q + stride_ext;
        issue_cnt_q <= issue_cnt_q + LEN_W'(1);
      end
      if (beat_fire) send_cnt_q <= send_cnt_q + LEN_W'(1);
    end
  end

  // Outstanding-read tracking and the sticky unsolicited-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      err_rsp       <= 1'b0;
    end else begin
      case ({rd_fire, rsp_ok})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (ram_rsp_vld && (outstanding_q == '0)) err_rsp <= 1'b1;
      else if (cmd_acc)                        err_rsp <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_stream_fetch_buffer.sv
// Scoreboard bench for ram_stream_fetch_buffer: RAM model with in-order random latency, MXU sink with stalls.
module tb_ram_stream_fetch_buffer;

  localparam int unsigned DW = 128, AW = 8, DEPTH = 16, LEN_W = 8, STRIDE_W = 5;
  localparam int unsigned SW = DW / 8, BW = $clog2(SW);

  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } beat_t;
  typedef struct { logic [DW-1:0] data; int unsigned due; } rsp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_vld = 1'b0;
  logic                cmd_rdy;
  logic [AW-1:0]       cmd_addr = '0;
  logic [STRIDE_W-1:0] cmd_stride = '0;
  logic [LEN_W-1:0]    cmd_len = '0;
  logic [BW-1:0]       cmd_start_byte = '0;
  logic [BW-1:0]       cmd_end_byte = '0;
  logic                ram_rd_vld;
  logic                ram_rd_rdy = 1'b0;
  logic [AW-1:0]       ram_rd_addr;
  logic                ram_rsp_vld = 1'b0;
  logic [DW-1:0]       ram_rsp_data = '0;
  logic                mxu_vld;
  logic                mxu_rdy = 1'b0;
  logic [DW-1:0]       mxu_data;
  logic [SW-1:0]       mxu_strb;
  logic                mxu_last;
  logic                busy;
  logic                err_rsp;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  rsp_t          pend_q[$];
  rsp_t          cur_rsp;
  beat_t         held, eb;
  logic          held_v = 1'b0;
  int unsigned   cyc = 0;
  int            n_checks = 0, n_fail = 0;
  int unsigned   rd_fire_cnt = 0, beats_recv = 0, base = 0;
  int            rd_rdy_mode = 0, mxu_rdy_mode = 1;
  int unsigned   lat_min = 2, lat_max = 2, last_due = 0, lat, due;
  logic [7:0]    salt = 8'h00;

  ram_stream_fetch_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_addr       (cmd_addr),
    .cmd_stride     (cmd_stride),
    .cmd_len        (cmd_len),
    .cmd_start_byte (cmd_start_byte),
    .cmd_end_byte   (cmd_end_byte),
    .ram_rd_vld     (ram_rd_vld),
    .ram_rd_rdy     (ram_rd_rdy),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rsp_vld    (ram_rsp_vld),
    .ram_rsp_data   (ram_rsp_data),
    .mxu_vld        (mxu_vld),
    .mxu_rdy        (mxu_rdy),
    .mxu_data       (mxu_data),
    .mxu_strb       (mxu_strb),
    .mxu_last       (mxu_last),
    .busy           (busy),
    .err_rsp        (err_rsp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a, input logic [7:0] s);
    logic [DW-1:0] w;
    for (int i = 0; i < SW; i++) w[i*8 +: 8] = a ^ s ^ 8'(i * 37 + 1);
    return w;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM request side: check addresses, schedule in-order responses
  initial forever begin
    @(negedge clk);
    if (rst_n && ram_rd_vld && ram_rd_rdy) begin
      rd_fire_cnt++;
      if (exp_addr_q.size() == 0) check("rd_spurious", ram_rd_vld, 1'b0);
      else check("rd_addr", ram_rd_addr, exp_addr_q.pop_front());
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{ram_word(ram_rd_addr, salt), due});
    end
  end

  // RAM response driver
  initial forever begin
    @(posedge clk); #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      cur_rsp = pend_q.pop_front();
      ram_rsp_vld  = 1'b1;
      ram_rsp_data = cur_rsp.data;
    end else begin
      ram_rsp_vld  = 1'b0;
      ram_rsp_data = '0;
    end
  end

  // Ready drivers
  initial forever begin
    @(posedge clk); #1;
    ram_rd_rdy = (rd_rdy_mode == 0) ? 1'b1 : (($urandom % 3) != 0);
    mxu_rdy    = (mxu_rdy_mode == 0) ? 1'b0 : (mxu_rdy_mode == 1) ? 1'b1 : (($urandom % 3) != 0);
  end

  // MXU monitor: stability during stalls, scoreboard compare on handshake
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_vld", mxu_vld, 1'b1);
        check("hold_data", mxu_data, held.data);
        check("hold_strb", mxu_strb, held.strb);
        check("hold_last", mxu_last, held.last);
      end
      if (!mxu_vld) begin
        check("idle_strb", mxu_strb, '0);
        check("idle_last", mxu_last, 1'b0);
      end
      if (mxu_vld && mxu_rdy) begin
        beats_recv++;
        if (exp_q.size() == 0) check("mxu_spurious", mxu_vld, 1'b0);
        else begin
          eb = exp_q.pop_front();
          check("mxu_data", mxu_data, eb.data);
          check("mxu_strb", mxu_strb, eb.strb);
          check("mxu_last", mxu_last, eb.last);
        end
      end
      held_v = mxu_vld && !mxu_rdy;
      held   = '{mxu_data, mxu_strb, mxu_last};
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [STRIDE_W-1:0] st,
                          input int unsigned len, input int unsigned sb, input int unsigned se);
    beat_t         b;
    logic [AW-1:0] ba;
    logic [DW-1:0] w;
    salt = salt + 8'd29;
    for (int unsigned k = 0; k <= len; k++) begin
      ba = AW'(int'(a) + int'($signed(st)) * int'(k));
      exp_addr_q.push_back(ba);
      w = ram_word(ba, salt);
      for (int unsigned i = 0; i < SW; i++) begin
        b.strb[i] = ((k != 0) || (i >= sb)) && ((k != len) || (i <= se));
        b.data[i*8 +: 8] = b.strb[i] ? w[i*8 +: 8] : 8'h00;
      end
      b.last = (k == len);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    cmd_addr = a; cmd_stride = st; cmd_len = LEN_W'(len);
    cmd_start_byte = BW'(sb); cmd_end_byte = BW'(se);
    cmd_vld = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_rdy) break;
    end
    check("cmd_rdy_wait", cmd_rdy, 1'b1);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && pend_q.size() == 0) break;
    end
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
    check({tag, "_rd_vld"}, ram_rd_vld, 1'b0);
    check({tag, "_rd_addr"}, ram_rd_addr, '0);
    check({tag, "_mxu_vld"}, mxu_vld, 1'b0);
    check({tag, "_mxu_data"}, mxu_data, '0);
    check({tag, "_mxu_strb"}, mxu_strb, '0);
    check({tag, "_mxu_last"}, mxu_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err_rsp, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Unit stride, partial first/last beats
    send_cmd(8'h10, 5'd1, 3, 4, 11);
    wait_idle("t1", 200);

    // Negative stride with address wrap; cmd_vld while busy is ignored
    mxu_rdy_mode = 0;
    send_cmd(8'h02, 5'b11110, 2, 0, 15);
    cmd_addr = 8'hAA; cmd_stride = 5'd3; cmd_len = 8'd9; cmd_vld = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    cmd_vld = 1'b0;
    check("t2_busy", busy, 1'b1);
    mxu_rdy_mode = 1;
    wait_idle("t2", 200);

    // Credit limit: only DEPTH reads while the sink is stalled
    mxu_rdy_mode = 0;
    base = rd_fire_cnt;
    send_cmd(8'hF0, 5'd1, 31, 0, 15);
    repeat (40) @(negedge clk);
    check("t3_reads", rd_fire_cnt - base, DEPTH);
    check("t3_rd_vld", ram_rd_vld, 1'b0);
    check("t3_mxu_vld", mxu_vld, 1'b1);
    base = beats_recv;
    mxu_rdy_mode = 1;
    wait_idle("t3", 400);
    check("t3_beats", beats_recv - base, 32);

    // Single beat, both masks applied; busy drops after the handshake
    send_cmd(8'h33, 5'd1, 0, 3, 3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mxu_vld && mxu_rdy) break;
    end
    check("t4_strb", mxu_strb, 16'h0008);
    check("t4_last", mxu_last, 1'b1);
    check("t4_busy_hs", busy, 1'b1);
    @(negedge clk);
    check("t4_busy_after", busy, 1'b0);
    wait_idle("t4", 50);

    // Random stalls and latencies
    rd_rdy_mode = 1; mxu_rdy_mode = 2; lat_min = 1; lat_max = 6;
    for (int n = 0; n < 200; n++) begin
      send_cmd(8'($urandom), 5'($urandom), $urandom_range(20, 0),
               $urandom_range(SW - 1, 0), $urandom_range(SW - 1, 0));
      wait_idle("t5", 2000);
    end

    // Reset with three reads outstanding
    rd_rdy_mode = 0; mxu_rdy_mode = 1; lat_min = 6; lat_max = 6;
    base = rd_fire_cnt;
    send_cmd(8'h40, 5'd1, 7, 0, 15);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (rd_fire_cnt - base >= 3) break;
    end
    check("t6_issued", rd_fire_cnt - base, 3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    check_reset_outputs("t6");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pend_q.size() == 0) break;
    end
    repeat (2) @(negedge clk);
    check("t6_err_set", err_rsp, 1'b1);
    check("t6_mxu_vld", mxu_vld, 1'b0);
    lat_min = 2; lat_max = 2;
    send_cmd(8'h00, 5'd1, 1, 0, 15);
    check("t6_err_clr", err_rsp, 1'b0);
    wait_idle("t6", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
